ysyx_23060184_axi_arbiter: RTL and testbench

//  Upstream bus arbiter feeding the SRAM and UART slaves. Picks one master (IFU read or LSU read/write).

---
 rtl/ysyx_23060184_axi_arbiter_pkg.sv | 36 +++
 rtl/ysyx_23060184_addr_decode.sv | 22 ++
 rtl/ysyx_23060184_axi_arbiter.sv | 129 ++++++++++++
 tb/tb_ysyx_23060184_axi_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060184_axi_arbiter_pkg.sv
// Shared grant codes, widths and FSM encodings for the upstream arbiter and the
// slaves that decode its grant.
package ysyx_23060184_axi_arbiter_pkg;

   localparam int NUM_ARB_MASTERS = 2;
   localparam int DATA_WIDTH      = 32;

   localparam logic [NUM_ARB_MASTERS-1:0] EMPTY_GRANT   = 2'b00;
   localparam logic [NUM_ARB_MASTERS-1:0] INSTMEM_GRANT = 2'b01;
   localparam logic [NUM_ARB_MASTERS-1:0] DATAMEM_GRANT = 2'b10;
   localparam logic [NUM_ARB_MASTERS-1:0] UART_GRANT    = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      G_INST = 2'b01,
      G_DATA = 2'b10,
      G_UART = 2'b11
   } arb_state_t;

   typedef enum logic {
      LAST_INST = 1'b0,
      LAST_DATA = 1'b1
   } master_t;

   function automatic logic [NUM_ARB_MASTERS-1:0] state_to_grant(input arb_state_t s);
      logic [NUM_ARB_MASTERS-1:0] g;
      case (s)
         G_INST:  g = INSTMEM_GRANT;
         G_DATA:  g = DATAMEM_GRANT;
         G_UART:  g = UART_GRANT;
         default: g = EMPTY_GRANT;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/ysyx_23060184_addr_decode.sv
// Combinational UART-window check for LSU addresses; the upper bound is formed one
// bit wider so a window touching the top of the address space does not wrap.
module ysyx_23060184_addr_decode
   import ysyx_23060184_axi_arbiter_pkg::*;
#(
   parameter logic [DATA_WIDTH-1:0] UART_BASE = 32'ha000_03f8,
   parameter logic [DATA_WIDTH-1:0] UART_SIZE = 32'h8
) (
   input  logic [DATA_WIDTH-1:0] addr,
   output logic                  is_uart
);

   logic [DATA_WIDTH:0] base_ext;
   logic [DATA_WIDTH:0] limit_ext;
   logic [DATA_WIDTH:0] addr_ext;

   assign base_ext  = {1'b0, UART_BASE};
   assign limit_ext = base_ext + {1'b0, UART_SIZE};
   assign addr_ext  = {1'b0, addr};
   assign is_uart   = (addr_ext >= base_ext) && (addr_ext < limit_ext);

endmodule

// File: rtl/ysyx_23060184_axi_arbiter.sv
// Upstream arbiter: round-robins IFU and LSU, routes LSU to SRAM or UART, holds the
// grant until the response handshake, and forces release after a watchdog period.
module ysyx_23060184_axi_arbiter
   import ysyx_23060184_axi_arbiter_pkg::*;
#(
   parameter logic [DATA_WIDTH-1:0] UART_BASE      = 32'ha000_03f8,
   parameter logic [DATA_WIDTH-1:0] UART_SIZE      = 32'h8,
   parameter int                    TIMEOUT_CYCLES = 255
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       i_arvalid,
   input  logic                       i_rready,
   input  logic [DATA_WIDTH-1:0]      d_araddr,
   input  logic                       d_arvalid,
   input  logic                       d_rready,
   input  logic [DATA_WIDTH-1:0]      d_awaddr,
   input  logic                       d_awvalid,
   input  logic                       d_bready,
   input  logic                       sram_rvalid,
   input  logic                       sram_bvalid,
   input  logic                       uart_rvalid,
   input  logic                       uart_bvalid,
   output logic [NUM_ARB_MASTERS-1:0] grant,
   output logic                       busy,
   output logic                       timeout_err
);

   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

   arb_state_t                 state_reg, state_next;
   master_t                    last_reg, last_next;
   logic [CNT_W-1:0]           cnt_reg, cnt_next;
   logic                       is_write_reg, is_write_next;
   logic                       timeout_reg, timeout_next;
   logic [NUM_ARB_MASTERS-1:0] grant_reg;
   logic                       busy_reg;

   logic                  req_i;
   logic                  req_d;
   logic                  pick_inst;
   logic                  lsu_write;
   logic [DATA_WIDTH-1:0] lsu_addr;
   logic                  lsu_is_uart;
   logic                  done;
   logic                  expired;

   assign req_i     = i_arvalid;
   assign req_d     = d_arvalid | d_awvalid;
   assign pick_inst = req_i & (~req_d | (last_reg == LAST_DATA));
   assign lsu_write = ~d_arvalid;
   assign lsu_addr  = lsu_write ? d_awaddr : d_araddr;
   assign expired   = (cnt_reg == CNT_LAST);

   ysyx_23060184_addr_decode #(
      .UART_BASE (UART_BASE),
      .UART_SIZE (UART_SIZE)
   ) u_addr_decode (
      .addr    (lsu_addr),
      .is_uart (lsu_is_uart)
   );

   // Only the granted slave's response pair can finish the transaction.
   always_comb begin
      done = 1'b0;
      case (state_reg)
         G_INST:  done = sram_rvalid & i_rready;
         G_DATA:  done = is_write_reg ? (sram_bvalid & d_bready) : (sram_rvalid & d_rready);
         G_UART:  done = is_write_reg ? (uart_bvalid & d_bready) : (uart_rvalid & d_rready);
         default: done = 1'b0;
      endcase
   end

   always_comb begin
      state_next    = state_reg;
      last_next     = last_reg;
      cnt_next      = cnt_reg;
      is_write_next = is_write_reg;
      timeout_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (pick_inst) begin
               state_next = G_INST;
               cnt_next   = '0;
            end else if (req_d) begin
               state_next    = lsu_is_uart ? G_UART : G_DATA;
               is_write_next = lsu_write;
               cnt_next      = '0;
            end
         end
         default: begin
            if (done || expired) begin
               state_next   = IDLE;
               last_next    = (state_reg == G_INST) ? LAST_INST : LAST_DATA;
               timeout_next = ~done;
            end else if (cnt_reg != CNT_MAX) begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_reg    <= IDLE;
         last_reg     <= LAST_DATA;
         cnt_reg      <= '0;
         is_write_reg <= 1'b0;
         timeout_reg  <= 1'b0;
         grant_reg    <= EMPTY_GRANT;
         busy_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         last_reg     <= last_next;
         cnt_reg      <= cnt_next;
         is_write_reg <= is_write_next;
         timeout_reg  <= timeout_next;
         grant_reg    <= state_to_grant(state_next);
         busy_reg     <= (state_next != IDLE);
      end
   end

   assign grant       = grant_reg;
   assign busy        = busy_reg;
   assign timeout_err = timeout_reg;

endmodule

// File: tb/tb_ysyx_23060184_axi_arbiter.sv
// Self-checking bench: directed scenarios with fixed expectations, then randomized
// traffic compared cycle by cycle against a transaction-level model.
module tb_ysyx_23060184_axi_arbiter;

   localparam int     TO          = 4;
   localparam longint UART_BASE_L = 64'ha000_03f8;
   localparam longint UART_SIZE_L = 64'h8;

   logic        clk = 1'b0;
   logic        rstn;
   logic        i_arvalid, i_rready;
   logic [31:0] d_araddr, d_awaddr;
   logic        d_arvalid, d_rready, d_awvalid, d_bready;
   logic        sram_rvalid, sram_bvalid, uart_rvalid, uart_bvalid;
   logic [1:0]  grant;
   logic        busy, timeout_err;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: who owns the bus, how long it has held it, who went last.
   int m_grant     = 0;
   bit m_last_inst = 1'b0;
   int m_held      = 0;
   bit m_write     = 1'b0;
   bit m_err       = 1'b0;

   ysyx_23060184_axi_arbiter #(
      .UART_BASE      (32'ha000_03f8),
      .UART_SIZE      (32'h8),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .i_arvalid   (i_arvalid),
      .i_rready    (i_rready),
      .d_araddr    (d_araddr),
      .d_arvalid   (d_arvalid),
      .d_rready    (d_rready),
      .d_awaddr    (d_awaddr),
      .d_awvalid   (d_awvalid),
      .d_bready    (d_bready),
      .sram_rvalid (sram_rvalid),
      .sram_bvalid (sram_bvalid),
      .uart_rvalid (uart_rvalid),
      .uart_bvalid (uart_bvalid),
      .grant       (grant),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic model_step();
      bit     fin;
      longint addr;
      if (!rstn) begin
         m_grant = 0; m_last_inst = 1'b0; m_held = 0; m_err = 1'b0; m_write = 1'b0;
      end else if (m_grant == 0) begin
         m_err = 1'b0;
         if (i_arvalid && (!(d_arvalid || d_awvalid) || !m_last_inst)) begin
            m_grant = 1; m_held = 0;
         end else if (d_arvalid || d_awvalid) begin
            m_write = !d_arvalid;
            addr    = m_write ? {32'h0, d_awaddr} : {32'h0, d_araddr};
            m_grant = (addr >= UART_BASE_L && addr < UART_BASE_L + UART_SIZE_L) ? 3 : 2;
            m_held  = 0;
         end
      end else begin
         case (m_grant)
            1:       fin = sram_rvalid && i_rready;
            2:       fin = m_write ? (sram_bvalid && d_bready) : (sram_rvalid && d_rready);
            default: fin = m_write ? (uart_bvalid && d_bready) : (uart_rvalid && d_rready);
         endcase
         if (fin || m_held + 1 == TO) begin
            m_last_inst = (m_grant == 1);
            m_err       = !fin;
            m_grant     = 0;
            m_held      = 0;
         end else begin
            m_held++;
            m_err = 1'b0;
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      i_arvalid = 0; i_rready = 0; d_arvalid = 0; d_rready = 0; d_awvalid = 0; d_bready = 0;
      sram_rvalid = 0; sram_bvalid = 0; uart_rvalid = 0; uart_bvalid = 0;
      d_araddr = 32'h0; d_awaddr = 32'h0;
   endtask

   task automatic test_reset();
      rstn = 0; i_arvalid = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: cycle %0d grant=%b expected=00", i, grant); end
         n_checks++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: busy=%b timeout_err=%b expected=0/0", busy, timeout_err); end
      end
      rstn = 1;
      tick();
      n_checks++; if (grant !== 2'b01 || busy !== 1'b1) begin n_fail++; $display("FAIL reset_release: grant=%b busy=%b expected=01/1", grant, busy); end
   endtask

   task automatic test_ifu_read();
      i_arvalid = 0;
      tick();
      n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL ifu_hold: grant=%b expected=01", grant); end
      sram_rvalid = 1; i_rready = 1;
      tick();
      n_checks++; if (grant !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL ifu_complete: grant=%b busy=%b expected=00/0", grant, busy); end
      sram_rvalid = 0; i_rready = 0; d_arvalid = 1; d_araddr = 32'h8000_0000;
      tick();
      n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL lsu_read_grant: grant=%b expected=10", grant); end
      d_arvalid = 0; sram_rvalid = 1; d_rready = 1;
      tick();
      n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL lsu_read_complete: grant=%b expected=00", grant); end
      clear_inputs();
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_seq [7];
      exp_seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
      i_arvalid = 1; d_arvalid = 1; d_araddr = 32'h8000_0000;
      sram_rvalid = 1; i_rready = 1; d_rready = 1;
      for (int i = 0; i < 7; i++) begin
         tick();
         n_checks++; if (grant !== exp_seq[i]) begin n_fail++; $display("FAIL round_robin: step %0d grant=%b expected=%b", i, grant, exp_seq[i]); end
      end
      i_arvalid = 0; d_arvalid = 0;
      tick();
      n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL round_robin_drain: grant=%b expected=00", grant); end
      clear_inputs();
   endtask

   task automatic test_uart_decode();
      logic [31:0] addrs [3];
      logic [1:0]  exps  [3];
      addrs = '{32'ha000_0400, 32'ha000_03ff, 32'ha000_03f7};
      exps  = '{2'b10, 2'b11, 2'b10};
      d_awvalid = 1; d_awaddr = 32'ha000_03f8;
      tick();
      n_checks++; if (grant !== 2'b11) begin n_fail++; $display("FAIL uart_write_grant: grant=%b expected=11", grant); end
      d_awvalid = 0; sram_bvalid = 1; d_bready = 1; uart_rvalid = 1; d_rready = 1;
      tick();
      n_checks++; if (grant !== 2'b11) begin n_fail++; $display("FAIL uart_ignore_other: grant=%b expected=11", grant); end
      sram_bvalid = 0; uart_rvalid = 0; uart_bvalid = 1;
      tick();
      n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL uart_write_complete: grant=%b expected=00", grant); end
      clear_inputs();
      for (int i = 0; i < 3; i++) begin
         d_awvalid = 1; d_awaddr = addrs[i];
         tick();
         n_checks++; if (grant !== exps[i]) begin n_fail++; $display("FAIL uart_boundary: addr=%h grant=%b expected=%b", addrs[i], grant, exps[i]); end
         d_awvalid = 0; sram_bvalid = 1; uart_bvalid = 1; d_bready = 1;
         tick();
         n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL uart_boundary_done: addr=%h grant=%b expected=00", addrs[i], grant); end
         clear_inputs();
      end
      // read wins over write; a read must not complete on a write response
      d_arvalid = 1; d_araddr = 32'ha000_03fc; d_awvalid = 1; d_awaddr = 32'h8000_0000;
      tick();
      n_checks++; if (grant !== 2'b11) begin n_fail++; $display("FAIL read_priority: grant=%b expected=11", grant); end
      d_arvalid = 0; d_awvalid = 0; uart_bvalid = 1; d_bready = 1;
      tick();
      n_checks++; if (grant !== 2'b11) begin n_fail++; $display("FAIL uart_read_hold: grant=%b expected=11", grant); end
      uart_bvalid = 0; uart_rvalid = 1; d_rready = 1;
      tick();
      n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL uart_read_complete: grant=%b expected=00", grant); end
      clear_inputs();
   endtask

   task automatic test_timeout();
      d_arvalid = 1; d_araddr = 32'h8000_0000;
      tick();
      n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL timeout_grant: grant=%b expected=10", grant); end
      d_arvalid = 0;
      for (int i = 0; i < TO - 1; i++) begin
         tick();
         n_checks++; if (grant !== 2'b10 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_hold: cycle %0d grant=%b err=%b expected=10/0", i, grant, timeout_err); end
      end
      tick();
      n_checks++; if (grant !== 2'b00 || timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_fire: grant=%b err=%b expected=00/1", grant, timeout_err); end
      tick();
      n_checks++; if (grant !== 2'b00 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse: grant=%b err=%b expected=00/0", grant, timeout_err); end
      i_arvalid = 1;
      tick();
      n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL timeout_ifu_grant: grant=%b expected=01", grant); end
      i_arvalid = 0;
      for (int i = 0; i < TO - 1; i++) tick();
      n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL timeout_ifu_hold: grant=%b expected=01", grant); end
      sram_rvalid = 1; i_rready = 1;
      tick();
      n_checks++; if (grant !== 2'b00 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_completion_wins: grant=%b err=%b expected=00/0", grant, timeout_err); end
      clear_inputs();
      tick();
   endtask

   task automatic test_reset_mid_write();
      d_awvalid = 1; d_awaddr = 32'h8000_0010;
      tick();
      d_awvalid = 0;
      tick();
      n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL midreset_pre: grant=%b expected=10", grant); end
      rstn = 0;
      tick();
      n_checks++; if (grant !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL midreset_abort: grant=%b busy=%b expected=00/0", grant, busy); end
      rstn = 1; sram_bvalid = 1; d_bready = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++; if (grant !== 2'b00 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL midreset_stray_b: grant=%b err=%b expected=00/0", grant, timeout_err); end
      end
      clear_inputs();
      i_arvalid = 1; d_arvalid = 1; d_araddr = 32'h8000_0000;
      tick();
      n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL midreset_last_served: grant=%b expected=01", grant); end
      i_arvalid = 0; d_arvalid = 0; sram_rvalid = 1; i_rready = 1;
      tick();
      clear_inputs();
      tick();
   endtask

   task automatic test_random();
      logic [31:0] pool [4];
      pool = '{32'h8000_0000, 32'ha000_03f8, 32'ha000_03ff, 32'ha000_0400};
      for (int i = 0; i < 500; i++) begin
         rstn        = ($urandom_range(63) != 0);
         i_arvalid   = ($urandom_range(2) == 0);
         d_arvalid   = ($urandom_range(3) == 0);
         d_awvalid   = ($urandom_range(3) == 0);
         d_araddr    = ($urandom_range(1) == 0) ? pool[$urandom_range(3)] : 32'ha000_03f0 + 32'($urandom_range(31));
         d_awaddr    = ($urandom_range(1) == 0) ? pool[$urandom_range(3)] : $urandom;
         i_rready    = ($urandom_range(1) == 0);
         d_rready    = ($urandom_range(1) == 0);
         d_bready    = ($urandom_range(1) == 0);
         sram_rvalid = ($urandom_range(3) == 0);
         sram_bvalid = ($urandom_range(3) == 0);
         uart_rvalid = ($urandom_range(3) == 0);
         uart_bvalid = ($urandom_range(3) == 0);
         tick();
         n_checks++; if (grant !== 2'(m_grant)) begin n_fail++; $display("FAIL random_grant: cycle %0d grant=%b expected=%b", i, grant, 2'(m_grant)); end
         n_checks++; if (busy !== (m_grant != 0)) begin n_fail++; $display("FAIL random_busy: cycle %0d busy=%b expected=%b", i, busy, m_grant != 0); end
         n_checks++; if (timeout_err !== m_err) begin n_fail++; $display("FAIL random_timeout: cycle %0d err=%b expected=%b", i, timeout_err, m_err); end
      end
   endtask

   initial begin
      clear_inputs();
      rstn = 0;
      test_reset();
      test_ifu_read();
      test_round_robin();
      test_uart_decode();
      test_timeout();
      test_reset_mid_write();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
